// File: rtl/vendo_2p_fsm.sv
// Two-peso vending controller: debounced-edge coin detection on active-low p1/p5,
// Moore FSM that refunds excess credit one peso per cycle before a one-cycle dispense.
module vendo_2p_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic       p1,
  input  logic       p5,
  output logic       disp,
  output logic       change,
  output logic [2:0] cstate
);

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    ONE  = 3'b001,
    VEND = 3'b010,
    C1   = 3'b011,
    C2   = 3'b100,
    C3   = 3'b101,
    C4   = 3'b110,
    BAD  = 3'b111
  } state_t;

  state_t state_q, state_d;
  logic   p1_s_q, p1_h_q, p1_arm_q;
  logic   p5_s_q, p5_h_q, p5_arm_q;
  logic   disp_q, change_q;
  logic   p1_ev, p5_ev;

  // The arm bits stay clear until the raw input has been seen high since reset,
  // so a coin already held low when reset releases never registers as an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1_s_q   <= 1'b1;
      p1_h_q   <= 1'b1;
      p1_arm_q <= 1'b0;
      p5_s_q   <= 1'b1;
      p5_h_q   <= 1'b1;
      p5_arm_q <= 1'b0;
    end else begin
      p1_s_q   <= p1;
      p1_h_q   <= p1_s_q;
      p1_arm_q <= p1_arm_q | p1;
      p5_s_q   <= p5;
      p5_h_q   <= p5_s_q;
      p5_arm_q <= p5_arm_q | p5;
    end
  end

  assign p1_ev = p1_arm_q & p1_h_q & ~p1_s_q;
  assign p5_ev = p5_arm_q & p5_h_q & ~p5_s_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (p5_ev)      state_d = C3;
        else if (p1_ev) state_d = ONE;
      end
      ONE: begin
        if (p5_ev)      state_d = C4;
        else if (p1_ev) state_d = VEND;
      end
      C4:      state_d = C3;
      C3:      state_d = C2;
      C2:      state_d = C1;
      C1:      state_d = VEND;
      VEND:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      disp_q   <= 1'b0;
      change_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      disp_q   <= (state_d == VEND);
      change_q <= (state_d == C1) || (state_d == C2) ||
                  (state_d == C3) || (state_d == C4);
    end
  end

  assign disp   = disp_q;
  assign change = change_q;
  assign cstate = state_q;

endmodule

// File: tb/tb_vendo_2p_fsm.sv
// Self-checking bench for vendo_2p_fsm: credit/refund model compared every cycle,
// plus directed scenarios with literal expected cstate/disp/change values.
module tb_vendo_2p_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       p1 = 1'b1;
  logic       p5 = 1'b1;
  logic       disp, change;
  logic [2:0] cstate;

  int checks = 0;
  int failures = 0;

  vendo_2p_fsm dut (
    .clk    (clk),
    .reset  (reset),
    .p1     (p1),
    .p5     (p5),
    .disp   (disp),
    .change (change),
    .cstate (cstate)
  );

  always #5 clk = ~clk;

  // Model: credit in pesos, pesos still to refund, and a dispense flag.
  int m_credit = 0;
  int m_refund = 0;
  bit m_vend = 0;
  bit m1_cur = 1, m1_prev = 1, m1_seen_high = 0;
  bit m5_cur = 1, m5_prev = 1, m5_seen_high = 0;

  function automatic int m_cstate();
    if (m_vend)       return 2;
    if (m_refund > 0) return 2 + m_refund;
    return m_credit;
  endfunction

  always @(posedge clk or negedge reset) begin
    bit e1, e5;
    if (!reset) begin
      m_credit = 0; m_refund = 0; m_vend = 0;
      m1_cur = 1; m1_prev = 1; m1_seen_high = 0;
      m5_cur = 1; m5_prev = 1; m5_seen_high = 0;
    end else begin
      e1 = m1_seen_high && m1_prev && !m1_cur;
      e5 = m5_seen_high && m5_prev && !m5_cur;
      if (m_vend) begin
        m_vend = 0;
        m_credit = 0;
      end else if (m_refund > 0) begin
        m_refund = m_refund - 1;
        if (m_refund == 0) m_vend = 1;
      end else if (e5) begin
        m_refund = m_credit + 5 - 2;
        m_credit = 0;
      end else if (e1) begin
        m_credit = m_credit + 1;
        if (m_credit == 2) begin
          m_credit = 0;
          m_vend = 1;
        end
      end
      m1_seen_high = m1_seen_high | p1;
      m1_prev = m1_cur; m1_cur = p1;
      m5_seen_high = m5_seen_high | p5;
      m5_prev = m5_cur; m5_cur = p5;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cmp_cstate", int'(cstate), m_cstate());
    chk("cmp_disp",   int'(disp),   int'(m_vend));
    chk("cmp_change", int'(change), int'(m_refund > 0));
  end

  // Literal expectation on the DUT, and the same literal pinned against the model.
  task automatic lit(input string name, input int cs, input int d, input int c);
    chk({name, "_cstate"}, int'(cstate), cs);
    chk({name, "_disp"},   int'(disp),   d);
    chk({name, "_change"}, int'(change), c);
    chk({name, "_model"},  m_cstate(),   cs);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  initial begin
    #1 reset = 1'b0;
    tick(3);
    lit("reset_hold", 0, 0, 0);
    reset = 1'b1;
    tick(3);
    lit("idle_no_coin", 0, 0, 0);

    // single p1 held two cycles counts once
    p1 = 1'b0; tick();
    tick();           lit("p1_one", 1, 0, 0);
    p1 = 1'b1; tick(); lit("p1_hold_a", 1, 0, 0);
    tick();           lit("p1_hold_b", 1, 0, 0);
    reset = 1'b0; #1;
    lit("p1_async_reset", 0, 0, 0);
    tick(); reset = 1'b1; tick(2);

    // p5 from idle: 3 change, disp, idle
    p5 = 1'b0; tick();
    p5 = 1'b1; tick(); lit("p5_c3", 5, 0, 1);
    tick();           lit("p5_c2", 4, 0, 1);
    tick();           lit("p5_c1", 3, 0, 1);
    tick();           lit("p5_vend", 2, 1, 0);
    tick();           lit("p5_idle", 0, 0, 0);
    tick(2);

    // p1 then p5 as p1 rises: 4 change, disp
    p1 = 1'b0; tick();
    p1 = 1'b1; p5 = 1'b0; tick(); lit("p1p5_one", 1, 0, 0);
    p5 = 1'b1; tick(); lit("p1p5_c4", 6, 0, 1);
    tick();           lit("p1p5_c3", 5, 0, 1);
    tick();           lit("p1p5_c2", 4, 0, 1);
    tick();           lit("p1p5_c1", 3, 0, 1);
    tick();           lit("p1p5_vend", 2, 1, 0);
    tick();           lit("p1p5_idle", 0, 0, 0);
    tick(2);

    // two separated p1 coins: dispense without change
    p1 = 1'b0; tick();
    p1 = 1'b1; tick(); lit("p1p1_one", 1, 0, 0);
    tick();
    p1 = 1'b0; tick();
    p1 = 1'b1; tick(); lit("p1p1_vend", 2, 1, 0);
    tick();           lit("p1p1_idle", 0, 0, 0);
    tick(2);

    // p1 pulse while refunding is swallowed
    p5 = 1'b0; tick();
    p5 = 1'b1; tick(); lit("ign_c3", 5, 0, 1);
    p1 = 1'b0; tick(); lit("ign_c2", 4, 0, 1);
    p1 = 1'b1; tick(); lit("ign_c1", 3, 0, 1);
    tick();           lit("ign_vend", 2, 1, 0);
    tick();           lit("ign_idle", 0, 0, 0);
    tick(2);          lit("ign_stay", 0, 0, 0);

    // simultaneous p1/p5: p5 wins
    p1 = 1'b0; p5 = 1'b0; tick();
    p1 = 1'b1; p5 = 1'b1; tick(); lit("both_c3", 5, 0, 1);
    tick(3);          lit("both_vend", 2, 1, 0);
    tick();           lit("both_idle", 0, 0, 0);
    tick(2);

    // reset during C2 drops change immediately
    p5 = 1'b0; tick();
    p5 = 1'b1; tick(2); lit("rst_c2", 4, 0, 1);
    reset = 1'b0; #1;
    lit("rst_c2_async", 0, 0, 0);
    tick(); reset = 1'b1; tick(3);
    lit("rst_after", 0, 0, 0);

    // coin already low at reset release is not counted until it rises
    reset = 1'b0; p1 = 1'b0; tick(2);
    reset = 1'b1; tick(4);
    lit("held_low", 0, 0, 0);
    p1 = 1'b1; tick();
    p1 = 1'b0; tick();
    p1 = 1'b1; tick(); lit("held_then_edge", 1, 0, 0);
    p1 = 1'b0; tick();
    p1 = 1'b1; tick(); lit("held_vend", 2, 1, 0);
    tick(3);          lit("final_idle", 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
